// File: rtl/fetch_mem_arbiter.sv
// Arbiter sharing one fixed-latency, single-port memory between instruction fetch and data access.
// Accesses are serialised, held for LATENCY cycles and answered with registered per-requester valid pulses.
module fetch_mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int LATENCY     = 4,
  parameter int MAX_IF_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  input  logic              i_if_flush,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_valid,
  output logic              o_if_stall,
  input  logic              i_d_req,
  input  logic              i_d_wr,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_d_valid,
  output logic              o_d_stall,
  output logic              o_mem_en,
  output logic              o_mem_wr,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int CNT_W  = $clog2(LATENCY + 1);
  localparam int WAIT_W = $clog2(MAX_IF_WAIT + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_IF_WAIT);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_D
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_cancel;
  logic              r_mem_en;
  logic              r_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_if_valid;
  logic              r_d_valid;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic w_last;
  logic w_free;
  logic w_if_done;
  logic w_d_done;
  logic w_if_ok;
  logic w_force_if;
  logic w_grant_d;
  logic w_grant_if;

  // The last busy cycle doubles as an arbitration slot so back-to-back accesses leave no bubble.
  assign w_last     = (r_state != IDLE) && (r_cnt == '0);
  assign w_free     = (r_state == IDLE) || w_last;
  assign w_if_done  = w_last && (r_state == BUSY_IF) && !r_cancel && !i_if_flush;
  assign w_d_done   = w_last && (r_state == BUSY_D);
  assign w_if_ok    = i_if_req && !i_if_flush;
  assign w_force_if = w_if_ok && (r_wait_cnt == WAIT_MAX);
  assign w_grant_d  = w_free && i_d_req && !w_force_if;
  assign w_grant_if = w_free && w_if_ok && !w_grant_d;

  assign o_if_stall  = i_if_req && !w_if_done;
  assign o_d_stall   = i_d_req && !w_d_done;
  assign o_if_valid  = r_if_valid;
  assign o_d_valid   = r_d_valid;
  assign o_if_rdata  = r_if_rdata;
  assign o_d_rdata   = r_d_rdata;
  assign o_mem_en    = r_mem_en;
  assign o_mem_wr    = r_mem_wr;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_wait_cnt  <= '0;
      r_cancel    <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_valid  <= 1'b0;
      r_d_valid   <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_if_valid <= w_if_done;
      r_d_valid  <= w_d_done;
      if (w_if_done)
        r_if_rdata <= i_mem_rdata;
      if (w_d_done && !r_mem_wr)
        r_d_rdata <= i_mem_rdata;

      // A redirected fetch still runs to completion on the memory; only its valid pulse is dropped.
      if (w_last)
        r_cancel <= 1'b0;
      else if ((r_state == BUSY_IF) && i_if_flush)
        r_cancel <= 1'b1;

      if (w_grant_if) begin
        r_state     <= BUSY_IF;
        r_cnt       <= CNT_LOAD;
        r_mem_en    <= 1'b1;
        r_mem_wr    <= 1'b0;
        r_mem_addr  <= i_if_addr;
        r_mem_wdata <= '0;
      end else if (w_grant_d) begin
        r_state     <= BUSY_D;
        r_cnt       <= CNT_LOAD;
        r_mem_en    <= 1'b1;
        r_mem_wr    <= i_d_wr;
        r_mem_addr  <= i_d_addr;
        r_mem_wdata <= i_d_wdata;
      end else if (w_last) begin
        r_state  <= IDLE;
        r_mem_en <= 1'b0;
        r_mem_wr <= 1'b0;
      end else if (r_state != IDLE) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end

      // Counts data grants that jumped a waiting fetch, so fetch cannot be starved forever.
      if (!i_if_req || w_grant_if)
        r_wait_cnt <= '0;
      else if (w_grant_d && (r_wait_cnt != WAIT_MAX))
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Bench for fetch_mem_arbiter: per-cycle vector table, hand-written corner sequences and
// randomised traffic, all checked against a transaction-level model of the sharing rules.
module tb_fetch_mem_arbiter;

  localparam int LAT  = 4;
  localparam int MAXW = 2;

  logic        clk = 1'b0;
  logic        rstN;
  logic        ifReq, ifFlush, dReq, dWr;
  logic [15:0] ifAddr, dAddr, dWdata, memRdata;
  logic [15:0] ifRdata, dRdata, memAddr, memWdata;
  logic        ifValid, ifStall, dValid, dStall, memEn, memWr;

  always #5 clk = ~clk;

  fetch_mem_arbiter #(
    .ADDR_W(16), .DATA_W(16), .LATENCY(LAT), .MAX_IF_WAIT(MAXW)
  ) dut (
    .clk(clk), .rst_n(rstN),
    .i_if_req(ifReq), .i_if_addr(ifAddr), .i_if_flush(ifFlush),
    .o_if_rdata(ifRdata), .o_if_valid(ifValid), .o_if_stall(ifStall),
    .i_d_req(dReq), .i_d_wr(dWr), .i_d_addr(dAddr), .i_d_wdata(dWdata),
    .o_d_rdata(dRdata), .o_d_valid(dValid), .o_d_stall(dStall),
    .o_mem_en(memEn), .o_mem_wr(memWr), .o_mem_addr(memAddr), .o_mem_wdata(memWdata),
    .i_mem_rdata(memRdata)
  );

  int checks = 0;
  int failures = 0;

  // Model: owner 0 = none, 1 = fetch, 2 = data; mLeft = busy cycles remaining including this one.
  int          mOwner, mLeft, mWait;
  logic [15:0] mAddr, mWdata, mIfData, mDData;
  logic        mWr, mKilled, mIfv, mDv;

  logic        sIfValid, sDValid, sMemEn, sMemWr, sIfStall, sDStall;
  logic [15:0] sMemAddr, sMemWdata, sIfRdata, sDRdata;

  typedef struct {
    logic        ifReq;
    logic [15:0] ifAddr;
    logic        dReq;
    logic        dWr;
    logic [15:0] dAddr;
    logic [15:0] dWdata;
    logic [15:0] memRdata;
    logic        eMemEn;
    logic        eMemWr;
    logic [15:0] eMemAddr;
    logic [15:0] eMemWdata;
    logic        eIfValid;
    logic [15:0] eIfRdata;
    logic        eIfStall;
    logic        eDValid;
    logic [15:0] eDRdata;
    logic        eDStall;
  } vec_t;

  vec_t vecs[12];
  int   ifvCycle, dvCycle;
  int   dvq[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic void modelReset();
    mOwner = 0; mLeft = 0; mWait = 0;
    mAddr = '0; mWdata = '0; mWr = 1'b0; mKilled = 1'b0;
    mIfv = 1'b0; mDv = 1'b0; mIfData = '0; mDData = '0;
  endfunction

  task automatic applyStimulus(input vec_t v);
    ifReq = v.ifReq; ifAddr = v.ifAddr; ifFlush = 1'b0;
    dReq = v.dReq; dWr = v.dWr; dAddr = v.dAddr; dWdata = v.dWdata;
    memRdata = v.memRdata;
  endtask

  task automatic idleInputs();
    ifReq = 1'b0; ifAddr = '0; ifFlush = 1'b0;
    dReq = 1'b0; dWr = 1'b0; dAddr = '0; dWdata = '0; memRdata = '0;
  endtask

  // Samples the DUT mid-cycle, checks it against the model, then advances the model one clock.
  task automatic stepCycle();
    bit last, ifDone, dDone, pickIf, pickD;
    @(negedge clk);
    sIfValid = ifValid; sDValid = dValid; sMemEn = memEn; sMemWr = memWr;
    sIfStall = ifStall; sDStall = dStall; sMemAddr = memAddr; sMemWdata = memWdata;
    sIfRdata = ifRdata; sDRdata = dRdata;
    last   = (mOwner != 0) && (mLeft == 1);
    ifDone = last && (mOwner == 1) && !mKilled && !ifFlush;
    dDone  = last && (mOwner == 2);
    checkOutput("mem_en", memEn, mOwner != 0);
    checkOutput("mem_wr", memWr, (mOwner == 2) && mWr);
    if (mOwner != 0) checkOutput("mem_addr", memAddr, mAddr);
    if ((mOwner == 2) && mWr) checkOutput("mem_wdata", memWdata, mWdata);
    checkOutput("if_valid", ifValid, mIfv);
    checkOutput("d_valid", dValid, mDv);
    checkOutput("if_rdata", ifRdata, mIfData);
    checkOutput("d_rdata", dRdata, mDData);
    checkOutput("if_stall", ifStall, ifReq && !ifDone);
    checkOutput("d_stall", dStall, dReq && !dDone);
    mIfv = ifDone;
    mDv  = dDone;
    if (ifDone) mIfData = memRdata;
    if (dDone && !mWr) mDData = memRdata;
    if ((mOwner == 1) && !last && ifFlush) mKilled = 1'b1;
    pickIf = 1'b0;
    pickD  = 1'b0;
    if ((mOwner == 0) || last) begin
      pickIf = ifReq && !ifFlush && (!dReq || (mWait >= MAXW));
      pickD  = dReq && !pickIf;
      if (pickIf) begin
        mOwner = 1; mLeft = LAT; mAddr = ifAddr; mWr = 1'b0; mKilled = 1'b0;
      end else if (pickD) begin
        mOwner = 2; mLeft = LAT; mAddr = dAddr; mWr = dWr; mWdata = dWdata; mKilled = 1'b0;
      end else begin
        mOwner = 0; mLeft = 0;
      end
    end else begin
      mLeft--;
    end
    if (!ifReq || pickIf) mWait = 0;
    else if (pickD && (mWait < MAXW)) mWait++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Lone fetch of 0x0010 followed by a lone store of 0xBEEF to 0x0040.
    vecs[0]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0, 16'hA123, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0};
    vecs[1]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0, 16'hA123, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0};
    vecs[2]  = vecs[1];
    vecs[3]  = vecs[1];
    vecs[4]  = '{1'b0, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0, 16'hA123, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0};
    vecs[5]  = '{1'b0, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0, 16'hA123, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'hA123, 1'b0, 1'b0, 16'h0, 1'b0};
    vecs[6]  = '{1'b0, 16'h0, 1'b1, 1'b1, 16'h0040, 16'hBEEF, 16'h1234, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'hA123, 1'b0, 1'b0, 16'h0, 1'b1};
    vecs[7]  = '{1'b0, 16'h0, 1'b1, 1'b1, 16'h0040, 16'hBEEF, 16'h1234, 1'b1, 1'b1, 16'h0040, 16'hBEEF, 1'b0, 16'hA123, 1'b0, 1'b0, 16'h0, 1'b1};
    vecs[8]  = vecs[7];
    vecs[9]  = vecs[7];
    vecs[10] = '{1'b0, 16'h0, 1'b0, 1'b1, 16'h0040, 16'hBEEF, 16'h1234, 1'b1, 1'b1, 16'h0040, 16'hBEEF, 1'b0, 16'hA123, 1'b0, 1'b0, 16'h0, 1'b0};
    vecs[11] = '{1'b0, 16'h0, 1'b0, 1'b1, 16'h0040, 16'hBEEF, 16'h1234, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'hA123, 1'b0, 1'b1, 16'h0, 1'b0};

    rstN = 1'b0;
    idleInputs();
    modelReset();
    #2;
    checkOutput("rst_mem_en", memEn, 1'b0);
    checkOutput("rst_mem_wr", memWr, 1'b0);
    checkOutput("rst_mem_addr", memAddr, 16'h0);
    checkOutput("rst_if_valid", ifValid, 1'b0);
    checkOutput("rst_d_valid", dValid, 1'b0);
    checkOutput("rst_if_rdata", ifRdata, 16'h0);
    checkOutput("rst_d_rdata", dRdata, 16'h0);
    checkOutput("rst_if_stall_idle", ifStall, 1'b0);
    ifReq = 1'b1;
    dReq  = 1'b1;
    #1;
    checkOutput("rst_if_stall_req", ifStall, 1'b1);
    checkOutput("rst_d_stall_req", dStall, 1'b1);
    idleInputs();
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] vector table");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      stepCycle();
      checkOutput($sformatf("tbl%0d_mem_en", i), sMemEn, vecs[i].eMemEn);
      checkOutput($sformatf("tbl%0d_mem_wr", i), sMemWr, vecs[i].eMemWr);
      if (vecs[i].eMemEn) checkOutput($sformatf("tbl%0d_mem_addr", i), sMemAddr, vecs[i].eMemAddr);
      if (vecs[i].eMemWr) checkOutput($sformatf("tbl%0d_mem_wdata", i), sMemWdata, vecs[i].eMemWdata);
      checkOutput($sformatf("tbl%0d_if_valid", i), sIfValid, vecs[i].eIfValid);
      checkOutput($sformatf("tbl%0d_if_rdata", i), sIfRdata, vecs[i].eIfRdata);
      checkOutput($sformatf("tbl%0d_if_stall", i), sIfStall, vecs[i].eIfStall);
      checkOutput($sformatf("tbl%0d_d_valid", i), sDValid, vecs[i].eDValid);
      checkOutput($sformatf("tbl%0d_d_rdata", i), sDRdata, vecs[i].eDRdata);
      checkOutput($sformatf("tbl%0d_d_stall", i), sDStall, vecs[i].eDStall);
    end

    $display("[TB] contention: load wins, fetch issues in the load completion cycle");
    ifvCycle = -1;
    dvCycle  = -1;
    for (int c = 0; c < 12; c++) begin
      idleInputs();
      ifReq = (c <= 7); ifAddr = 16'h0200;
      dReq = (c == 0); dWr = 1'b0; dAddr = 16'h8000;
      memRdata = 16'hD000 + 16'(c);
      stepCycle();
      if (sDValid) begin dvCycle = c; checkOutput("t2_d_rdata", sDRdata, 16'hD004); end
      if (sIfValid) begin ifvCycle = c; checkOutput("t2_if_rdata", sIfRdata, 16'hD008); end
      if ((c >= 1) && (c <= 8)) checkOutput($sformatf("t2_mem_en_c%0d", c), sMemEn, 1'b1);
      if (c == 1) checkOutput("t2_mem_addr_load", sMemAddr, 16'h8000);
      if (c == 5) checkOutput("t2_mem_addr_fetch", sMemAddr, 16'h0200);
    end
    checkOutput("t2_d_valid_cycle", dvCycle, 5);
    checkOutput("t2_if_valid_cycle", ifvCycle, 9);

    $display("[TB] starvation: two stores then forced fetch");
    ifvCycle = -1;
    dvq.delete();
    for (int c = 0; c < 15; c++) begin
      idleInputs();
      ifReq = (c <= 11); ifAddr = 16'h0300;
      dReq = (c <= 11); dWr = 1'b1; dAddr = 16'h0400 + 16'(c); dWdata = 16'h1100 + 16'(c);
      memRdata = 16'hE000 + 16'(c);
      stepCycle();
      if (sDValid) dvq.push_back(c);
      if (sIfValid) ifvCycle = c;
      if (c == 4) checkOutput("t3_d_stall_done", sDStall, 1'b0);
      if (c == 5) begin
        checkOutput("t3_second_store_wr", sMemWr, 1'b1);
        checkOutput("t3_second_store_addr", sMemAddr, 16'h0404);
        checkOutput("t3_second_store_wdata", sMemWdata, 16'h1104);
      end
      if (c == 9) begin
        checkOutput("t3_fetch_wr", sMemWr, 1'b0);
        checkOutput("t3_fetch_addr", sMemAddr, 16'h0300);
      end
    end
    checkOutput("t3_store_count", dvq.size(), 2);
    if (dvq.size() == 2) begin
      checkOutput("t3_store0_valid_cycle", dvq[0], 5);
      checkOutput("t3_store1_valid_cycle", dvq[1], 9);
    end
    checkOutput("t3_if_valid_cycle", ifvCycle, 13);

    $display("[TB] redirect mid-fetch");
    ifvCycle = -1;
    dvCycle  = 0;
    for (int c = 0; c < 11; c++) begin
      idleInputs();
      ifReq = (c <= 7);
      ifAddr = (c <= 1) ? 16'h0020 : 16'h0100;
      ifFlush = (c == 2);
      memRdata = 16'hC000 + 16'(c);
      stepCycle();
      if (sIfValid) begin ifvCycle = c; dvCycle++; checkOutput("t4_if_rdata", sIfRdata, 16'hC008); end
      if ((c >= 1) && (c <= 8)) checkOutput($sformatf("t4_mem_en_c%0d", c), sMemEn, 1'b1);
      if (c == 3) checkOutput("t4_mem_addr_old", sMemAddr, 16'h0020);
      if (c == 4) checkOutput("t4_if_stall_cancelled", sIfStall, 1'b1);
      if (c == 5) checkOutput("t4_mem_addr_new", sMemAddr, 16'h0100);
    end
    checkOutput("t4_if_valid_count", dvCycle, 1);
    checkOutput("t4_if_valid_cycle", ifvCycle, 9);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      ifReq = ($urandom_range(0, 9) < 6);
      ifAddr = 16'($urandom);
      ifFlush = ($urandom_range(0, 9) == 0);
      dReq = ($urandom_range(0, 9) < 7);
      dWr = 1'($urandom_range(0, 1));
      dAddr = 16'($urandom);
      dWdata = 16'($urandom);
      memRdata = 16'($urandom);
      stepCycle();
    end
    idleInputs();
    for (int i = 0; i < 8; i++) stepCycle();

    $display("[TB] reset mid-access");
    idleInputs();
    dReq = 1'b1; dAddr = 16'h0500;
    stepCycle();
    dReq = 1'b0;
    stepCycle();
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("t6_mem_en", memEn, 1'b0);
    checkOutput("t6_mem_wr", memWr, 1'b0);
    checkOutput("t6_if_valid", ifValid, 1'b0);
    checkOutput("t6_d_valid", dValid, 1'b0);
    modelReset();
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) stepCycle();
    ifvCycle = -1;
    for (int c = 0; c < 8; c++) begin
      idleInputs();
      ifReq = (c <= 3); ifAddr = 16'h0600;
      memRdata = 16'h7777;
      stepCycle();
      if (sIfValid) begin ifvCycle = c; checkOutput("t6_if_rdata", sIfRdata, 16'h7777); end
    end
    checkOutput("t6_if_valid_cycle", ifvCycle, LAT + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
